// File: rtl/traffic_junction_ctrl_pkg.sv
// Shared types and defaults for the junction controller: phase encoding,
// lamp bundle and the per-phase lamp decode.
package traffic_pkg;

    typedef enum logic [3:0] {
        ALL_RED_A = 4'd0,
        NS_RA     = 4'd1,
        NS_G      = 4'd2,
        NS_A      = 4'd3,
        ALL_RED_B = 4'd4,
        EW_RA     = 4'd5,
        EW_G      = 4'd6,
        EW_A      = 4'd7,
        WALK      = 4'd8,
        FLASH     = 4'd9
    } phase_t;

    localparam int DEF_T_ALL_RED   = 2;
    localparam int DEF_T_RED_AMBER = 2;
    localparam int DEF_T_GREEN     = 8;
    localparam int DEF_T_AMBER     = 3;
    localparam int DEF_T_WALK      = 5;
    localparam int DEF_T_FLASH     = 4;

    typedef struct packed {
        logic ns_red;
        logic ns_amber;
        logic ns_green;
        logic ew_red;
        logic ew_amber;
        logic ew_green;
        logic walk;
    } lamps_t;

    localparam lamps_t LAMPS_RESET = '{ns_red: 1'b1, ew_red: 1'b1, default: 1'b0};

    // Moore lamp decode; flash_on only matters in FLASH.
    function automatic lamps_t lamps_for(phase_t p, logic flash_on);
        lamps_t l;
        l = '0;
        case (p)
            NS_RA:   begin l.ns_red = 1'b1; l.ns_amber = 1'b1; l.ew_red = 1'b1; end
            NS_G:    begin l.ns_green = 1'b1; l.ew_red = 1'b1; end
            NS_A:    begin l.ns_amber = 1'b1; l.ew_red = 1'b1; end
            EW_RA:   begin l.ew_red = 1'b1; l.ew_amber = 1'b1; l.ns_red = 1'b1; end
            EW_G:    begin l.ew_green = 1'b1; l.ns_red = 1'b1; end
            EW_A:    begin l.ew_amber = 1'b1; l.ns_red = 1'b1; end
            WALK:    begin l.ns_red = 1'b1; l.ew_red = 1'b1; l.walk = 1'b1; end
            FLASH:   begin l.ns_amber = flash_on; l.ew_amber = flash_on; end
            default: begin l.ns_red = 1'b1; l.ew_red = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_junction_ctrl_phase_timer.sv
// Phase down-counter: loads a value, decrements while enabled, flags zero.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Load has priority over decrement; the counter parks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/traffic_junction_ctrl.sv
// Two-road junction controller with pedestrian walk insertion and a
// flashing-amber fault mode. Lamp outputs are registered decodes of the
// next state so they change on the same edge as the phase.
module traffic_junction_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int T_ALL_RED   = DEF_T_ALL_RED,
    parameter int T_RED_AMBER = DEF_T_RED_AMBER,
    parameter int T_GREEN     = DEF_T_GREEN,
    parameter int T_AMBER     = DEF_T_AMBER,
    parameter int T_WALK      = DEF_T_WALK,
    parameter int T_FLASH     = DEF_T_FLASH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       ped_req,
    input  logic       fault,
    output logic       ns_red,
    output logic       ns_amber,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_amber,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_ack,
    output logic [3:0] phase
);

    phase_t           state, state_nxt;
    phase_t           ret_state, ret_nxt;
    logic             flash_on, flash_nxt;
    logic             pending;
    logic             walk_entry;
    logic             tmr_load, tmr_en, tmr_done;
    logic [CNT_W-1:0] tmr_val;
    lamps_t           lamps_q, lamps_nxt;

    function automatic logic [CNT_W-1:0] load_for(phase_t p);
        case (p)
            NS_RA, EW_RA: return CNT_W'(T_RED_AMBER - 1);
            NS_G, EW_G:   return CNT_W'(T_GREEN - 1);
            NS_A, EW_A:   return CNT_W'(T_AMBER - 1);
            WALK:         return CNT_W'(T_WALK - 1);
            FLASH:        return CNT_W'(T_FLASH - 1);
            default:      return CNT_W'(T_ALL_RED - 1);
        endcase
    endfunction

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(T_ALL_RED - 1))
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State register, walk return target and flash half-period phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ALL_RED_A;
            ret_state <= ALL_RED_A;
            flash_on  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            flash_on  <= flash_nxt;
        end
    end

    // Next-state and timer control; fault overrides enable.
    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        flash_nxt = flash_on;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_val   = '0;
        if (fault) begin
            state_nxt = FLASH;
            if (state != FLASH) begin
                flash_nxt = 1'b1;
                tmr_load  = 1'b1;
                tmr_val   = load_for(FLASH);
            end else if (tmr_done) begin
                flash_nxt = ~flash_on;
                tmr_load  = 1'b1;
                tmr_val   = load_for(FLASH);
            end else begin
                tmr_en = 1'b1;
            end
        end else if (state == FLASH) begin
            state_nxt = ALL_RED_A;
            flash_nxt = 1'b0;
            tmr_load  = 1'b1;
            tmr_val   = load_for(ALL_RED_A);
        end else if (enable) begin
            if (tmr_done) begin
                // WALK replaces the all-red phase after amber and then
                // resumes at that all-red phase, keeping road alternation.
                case (state)
                    ALL_RED_A: state_nxt = NS_RA;
                    NS_RA:     state_nxt = NS_G;
                    NS_G:      state_nxt = NS_A;
                    NS_A: begin
                        state_nxt = pending ? WALK : ALL_RED_B;
                        ret_nxt   = ALL_RED_B;
                    end
                    ALL_RED_B: state_nxt = EW_RA;
                    EW_RA:     state_nxt = EW_G;
                    EW_G:      state_nxt = EW_A;
                    EW_A: begin
                        state_nxt = pending ? WALK : ALL_RED_A;
                        ret_nxt   = ALL_RED_A;
                    end
                    WALK:      state_nxt = ret_state;
                    default:   state_nxt = ALL_RED_A;
                endcase
                tmr_load = 1'b1;
                tmr_val  = load_for(state_nxt);
            end else begin
                tmr_en = 1'b1;
            end
        end
    end

    assign walk_entry = (state_nxt == WALK) && (state != WALK);

    // Output decode of the upcoming state, captured by the output register.
    always_comb begin
        lamps_nxt = lamps_for(state_nxt, flash_nxt);
    end

    // Registered lamp drives and acknowledge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamps_q <= LAMPS_RESET;
            ped_ack <= 1'b0;
        end else begin
            lamps_q <= lamps_nxt;
            ped_ack <= walk_entry;
        end
    end

    // Pedestrian request latch; serving the request wins over a new one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= 1'b0;
        else if (walk_entry)
            pending <= 1'b0;
        else if (ped_req && state != WALK)
            pending <= 1'b1;
    end

    assign ns_red   = lamps_q.ns_red;
    assign ns_amber = lamps_q.ns_amber;
    assign ns_green = lamps_q.ns_green;
    assign ew_red   = lamps_q.ew_red;
    assign ew_amber = lamps_q.ew_amber;
    assign ew_green = lamps_q.ew_green;
    assign walk     = lamps_q.walk;
    assign phase    = state;

endmodule

// File: doc/traffic_junction_ctrl.md
TRAFFIC_JUNCTION_CTRL -- requirements
Module: traffic_junction_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the phase down-counter.
REQ-002 Parameter T_ALL_RED, default 2: cycles spent in each all-red clearance phase.
REQ-003 Parameter T_RED_AMBER, default 2: cycles of red+amber before green.
REQ-004 Parameter T_GREEN, default 8: cycles of green.
REQ-005 Parameter T_AMBER, default 3: cycles of amber after green.
REQ-006 Parameter T_WALK, default 5: cycles of the pedestrian walk phase.
REQ-007 Parameter T_FLASH, default 4: cycles per on or off half-period of the fault flash.
REQ-008 clk  in  1  single system clock; all state changes on posedge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 enable  in  1  1 = sequence advances; 0 = state and counter hold.
REQ-011 ped_req  in  1  pedestrian request; a single-cycle pulse is sufficient.
REQ-012 fault  in  1  level; 1 = flashing-amber fault mode.
REQ-013 ns_red, ns_amber, ns_green  out  1 each  north-south lamp drives.
REQ-014 ew_red, ew_amber, ew_green  out  1 each  east-west lamp drives.
REQ-015 walk  out  1  pedestrian walk lamp.
REQ-016 ped_ack  out  1  one-cycle pulse when a pending request is served.
REQ-017 phase  out  4  current state encoding, for debug and the bench.

Function
REQ-018 States: ALL_RED_A, NS_RA, NS_G, NS_A, ALL_RED_B, EW_RA, EW_G, EW_A, WALK, FLASH.
REQ-019 Normal order: ALL_RED_A > NS_RA > NS_G > NS_A > ALL_RED_B > EW_RA > EW_G > EW_A > ALL_RED_A.
REQ-020 Each timed state lasts exactly its T_* cycles with enable=1: the counter loads T-1 on entry, decrements each cycle, and the transition occurs on the cycle after it reads 0.
REQ-021 Lamps per state: ALL_RED/WALK both red; NS_RA ns red+amber; NS_G ns green; NS_A ns amber only; the non-active road is red; EW_* mirror the NS_* states.
REQ-022 All outputs are registered Moore decodes of the state; no combinational path from any input to any output.
REQ-023 A pending flag sets on any cycle with ped_req=1 while the state is not WALK; requests during WALK are ignored.
REQ-024 On leaving NS_A or EW_A with pending=1, the next state is WALK instead of ALL_RED_B/ALL_RED_A; WALK lasts T_WALK cycles with walk=1 and both roads red.
REQ-025 On WALK entry, ped_ack pulses for one cycle and pending clears in the same cycle.
REQ-026 After WALK, the next state is the all-red state that was bypassed, so the road alternation is preserved.
REQ-027 When fault=1, the next state is FLASH from any state regardless of enable; all red and green lamps are 0 and walk is 0.
REQ-028 In FLASH, ns_amber and ew_amber are identical; they are 1 for the first T_FLASH cycles, then toggle every T_FLASH cycles.
REQ-029 When fault falls, the next state is ALL_RED_A with a fresh counter, and pending is retained.
REQ-030 When enable=0 outside FLASH, state, counter, lamps and pending capture all hold; ped_req is still latched.
REQ-031 All T_* are >= 1 and fit in CNT_W bits; T=1 gives a one-cycle state.

Reset
REQ-032 Asserting rst immediately forces ALL_RED_A, counter=T_ALL_RED-1, pending=0, both reds=1, all other lamps=0, walk=0, ped_ack=0, phase=ALL_RED_A encoding.
REQ-033 Reset asserted mid-phase, including in WALK or FLASH, aborts that phase with no ped_ack.

Structure
REQ-034 Package traffic_pkg holds the state enum/encodings and the default T_* constants.
REQ-035 Sub-module phase_timer, a CNT_W down-counter with load value, load, enable and done, is instantiated once.

Verification
REQ-036 Use default parameters, enable=1, no requests: ns_green rises 4 cycles after rst release; the full cycle period is 30 cycles.
REQ-037 Pulse ped_req for one cycle during NS_G: after 3 NS_A cycles, WALK runs for 5 cycles with ped_act pulsing once; the sequence then goes ALL_RED_B > EW_RA.
REQ-038 Assert ped_req repeatedly during WALK: no second ped_ack and no second WALK occur.
REQ-039 Assert fault for 20 cycles mid-EW_G: both ambers read 1111 0000 1111 0000 1111; on release, the sequence restarts at ALL_RED_A with both roads red.
REQ-040 Drop enable for 10 cycles mid-NS_G: ns_green stays high; the total green time is still 8 enabled cycles.
REQ-041 Assert rst asynchronously mid-WALK: outputs go to the reset values before the next clock edge.
